// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and the move-speed encoding shared by the
// VGA sync generator and its tick divider.
package vga_timing_pkg;

  localparam int COUNT_W = 10;

  localparam logic [COUNT_W-1:0] H_VISIBLE_DEF    = 10'd640;
  localparam logic [COUNT_W-1:0] H_SYNC_START_DEF = 10'd656;
  localparam logic [COUNT_W-1:0] H_SYNC_END_DEF   = 10'd752;
  localparam logic [COUNT_W-1:0] H_MAX_DEF        = 10'd799;
  localparam logic [COUNT_W-1:0] V_VISIBLE_DEF    = 10'd480;
  localparam logic [COUNT_W-1:0] V_SYNC_START_DEF = 10'd490;
  localparam logic [COUNT_W-1:0] V_SYNC_END_DEF   = 10'd492;
  localparam logic [COUNT_W-1:0] V_MAX_DEF        = 10'd524;

  typedef enum logic [1:0] {
    SPEED_8 = 2'd0,
    SPEED_4 = 2'd1,
    SPEED_2 = 2'd2,
    SPEED_1 = 2'd3
  } speed_sel_e;

  // Frames per move for each speed setting.
  function automatic logic [3:0] speed_divisor(input speed_sel_e sel);
    logic [3:0] div;
    case (sel)
      SPEED_8: div = 4'd8;
      SPEED_4: div = 4'd4;
      SPEED_2: div = 4'd2;
      SPEED_1: div = 4'd1;
      default: div = 4'd8;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Count inputs and video/strobe outputs of the VGA sync generator.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic [COUNT_W-1:0] h_count;
  logic [COUNT_W-1:0] v_count;
  logic [1:0]         speed_sel;
  logic               hsync;
  logic               vsync;
  logic               display_en;
  logic [COUNT_W-1:0] pixel_x;
  logic [COUNT_W-1:0] pixel_y;
  logic               frame_tick;
  logic               move_tick;
  logic               range_err;

  modport master (
    output h_count, v_count, speed_sel,
    input  hsync, vsync, display_en, pixel_x, pixel_y,
    input  frame_tick, move_tick, range_err
  );

  modport slave (
    input  h_count, v_count, speed_sel,
    output hsync, vsync, display_en, pixel_x, pixel_y,
    output frame_tick, move_tick, range_err
  );
endinterface

// File: rtl/tick_divider.sv
// Counts frame events and emits a move strobe every N frames, N chosen by
// speed_sel at each frame event.
module tick_divider
  import vga_timing_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_event,
  input  speed_sel_e speed_sel,
  output logic       move_tick
);

  logic [2:0] count_reg;
  logic       move_tick_reg;
  logic [3:0] last_idx;

  assign last_idx = speed_divisor(speed_sel) - 4'd1;

  // Using >= rather than == lets a speed-up take effect on the very next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= 3'd0;
      move_tick_reg <= 1'b0;
    end else begin
      move_tick_reg <= 1'b0;
      if (frame_event) begin
        if ({1'b0, count_reg} >= last_idx) begin
          move_tick_reg <= 1'b1;
          count_reg     <= 3'd0;
        end else begin
          count_reg <= count_reg + 3'd1;
        end
      end
    end
  end

  assign move_tick = move_tick_reg;

endmodule

// File: rtl/vga_sync_gen.sv
// Registered VGA sync/display-enable decode from free-running h/v counts,
// plus frame-start and game-move strobes.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter logic [COUNT_W-1:0] H_VISIBLE    = H_VISIBLE_DEF,
  parameter logic [COUNT_W-1:0] H_SYNC_START = H_SYNC_START_DEF,
  parameter logic [COUNT_W-1:0] H_SYNC_END   = H_SYNC_END_DEF,
  parameter logic [COUNT_W-1:0] H_MAX        = H_MAX_DEF,
  parameter logic [COUNT_W-1:0] V_VISIBLE    = V_VISIBLE_DEF,
  parameter logic [COUNT_W-1:0] V_SYNC_START = V_SYNC_START_DEF,
  parameter logic [COUNT_W-1:0] V_SYNC_END   = V_SYNC_END_DEF,
  parameter logic [COUNT_W-1:0] V_MAX        = V_MAX_DEF,
  parameter logic               SYNC_POL     = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  vga_sync_gen_if.slave vid
);

  logic [COUNT_W-1:0] h;
  logic [COUNT_W-1:0] v;
  logic               range_bad;
  logic               h_sync_act;
  logic               v_sync_act;
  logic               visible;
  logic               at_origin;
  logic               frame_event;
  logic [COUNT_W-1:0] pixel_x_next;
  logic [COUNT_W-1:0] pixel_y_next;

  logic               hsync_reg;
  logic               vsync_reg;
  logic               display_en_reg;
  logic [COUNT_W-1:0] pixel_x_reg;
  logic [COUNT_W-1:0] pixel_y_reg;
  logic               frame_tick_reg;
  logic               range_err_reg;
  logic               prev_origin_reg;

  assign h = vid.h_count;
  assign v = vid.v_count;

  always_comb begin
    range_bad   = (h > H_MAX) || (v > V_MAX);
    h_sync_act  = !range_bad && (h >= H_SYNC_START) && (h < H_SYNC_END);
    v_sync_act  = !range_bad && (v >= V_SYNC_START) && (v < V_SYNC_END);
    visible     = !range_bad && (h < H_VISIBLE) && (v < V_VISIBLE);
    at_origin   = (h == '0) && (v == '0);
    // Edge-detect so a count held at (0,0) yields a single pulse.
    frame_event = at_origin && !prev_origin_reg;
  end

  genvar gi;
  generate
    for (gi = 0; gi < COUNT_W; gi++) begin : g_pix
      assign pixel_x_next[gi] = h[gi] & visible;
      assign pixel_y_next[gi] = v[gi] & visible;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_reg       <= ~SYNC_POL;
      vsync_reg       <= ~SYNC_POL;
      display_en_reg  <= 1'b0;
      pixel_x_reg     <= '0;
      pixel_y_reg     <= '0;
      frame_tick_reg  <= 1'b0;
      range_err_reg   <= 1'b0;
      // Starting "at origin" keeps release-from-reset from looking like a frame start.
      prev_origin_reg <= 1'b1;
    end else begin
      hsync_reg       <= h_sync_act ? SYNC_POL : ~SYNC_POL;
      vsync_reg       <= v_sync_act ? SYNC_POL : ~SYNC_POL;
      display_en_reg  <= visible;
      pixel_x_reg     <= pixel_x_next;
      pixel_y_reg     <= pixel_y_next;
      frame_tick_reg  <= frame_event;
      range_err_reg   <= range_err_reg | range_bad;
      prev_origin_reg <= at_origin;
    end
  end

  tick_divider u_tick_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_event (frame_event),
    .speed_sel   (speed_sel_e'(vid.speed_sel)),
    .move_tick   (vid.move_tick)
  );

  assign vid.hsync      = hsync_reg;
  assign vid.vsync      = vsync_reg;
  assign vid.display_en = display_en_reg;
  assign vid.pixel_x    = pixel_x_reg;
  assign vid.pixel_y    = pixel_y_reg;
  assign vid.frame_tick = frame_tick_reg;
  assign vid.range_err  = range_err_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: per-cycle model comparison plus
// directed scenarios with hand-computed expectations.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n;

  vga_sync_gen_if vid ();

  vga_sync_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vid)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outputs follow directly from the timing rules; the move
  // strobe counts frames seen since the last move and fires once that reaches N.
  logic        e_hs, e_vs, e_de, e_ft, e_mt, e_re;
  logic [9:0]  e_px, e_py;
  bit          m_prev_origin;
  int          m_frames;

  always @(posedge clk) begin
    int h, v, n;
    bit bad, origin;
    h = int'(vid.h_count);
    v = int'(vid.v_count);
    if (!rst_n) begin
      e_hs = 1; e_vs = 1; e_de = 0; e_px = 0; e_py = 0;
      e_ft = 0; e_mt = 0; e_re = 0;
      m_prev_origin = 1; m_frames = 0;
    end else begin
      bad    = (h > 799) || (v > 524);
      e_hs   = !(!bad && h >= 656 && h < 752);
      e_vs   = !(!bad && v >= 490 && v < 492);
      e_de   = !bad && h < 640 && v < 480;
      e_px   = e_de ? 10'(h) : 10'd0;
      e_py   = e_de ? 10'(v) : 10'd0;
      e_re   = e_re | bad;
      origin = (h == 0) && (v == 0);
      e_ft   = origin && !m_prev_origin;
      m_prev_origin = origin;
      e_mt   = 0;
      if (e_ft) begin
        n = 8 >> int'(vid.speed_sel);
        m_frames++;
        if (m_frames >= n) begin
          e_mt = 1;
          m_frames = 0;
        end
      end
    end
    #1;
    chk("hsync",      32'(vid.hsync),      32'(e_hs));
    chk("vsync",      32'(vid.vsync),      32'(e_vs));
    chk("display_en", 32'(vid.display_en), 32'(e_de));
    chk("pixel_x",    32'(vid.pixel_x),    32'(e_px));
    chk("pixel_y",    32'(vid.pixel_y),    32'(e_py));
    chk("frame_tick", 32'(vid.frame_tick), 32'(e_ft));
    chk("move_tick",  32'(vid.move_tick),  32'(e_mt));
    chk("range_err",  32'(vid.range_err),  32'(e_re));
  end

  bit cnt_on = 0;
  int de_cnt = 0, hs_cnt = 0, vs_cnt = 0;

  task automatic step(input int h, input int v);
    @(negedge clk);
    vid.h_count = 10'(h);
    vid.v_count = 10'(v);
    @(posedge clk);
    #2;
    if (cnt_on) begin
      de_cnt += int'(vid.display_en);
      hs_cnt += int'(!vid.hsync);
      vs_cnt += int'(!vid.vsync);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hsync"},      32'(vid.hsync),      32'd1);
    chk({tag, "_vsync"},      32'(vid.vsync),      32'd1);
    chk({tag, "_display_en"}, 32'(vid.display_en), 32'd0);
    chk({tag, "_pixel_x"},    32'(vid.pixel_x),    32'd0);
    chk({tag, "_pixel_y"},    32'(vid.pixel_y),    32'd0);
    chk({tag, "_frame_tick"}, 32'(vid.frame_tick), 32'd0);
    chk({tag, "_move_tick"},  32'(vid.move_tick),  32'd0);
    chk({tag, "_range_err"},  32'(vid.range_err),  32'd0);
  endtask

  // One compressed frame: end-of-frame, origin entry, first pixel.
  logic fr_ft, fr_mt;
  task automatic frame();
    step(799, 524);
    step(0, 0);
    fr_ft = vid.frame_tick;
    fr_mt = vid.move_tick;
    step(1, 0);
  endtask

  int lines [9] = '{0, 1, 479, 480, 489, 490, 491, 492, 524};
  int cols  [8] = '{0, 639, 640, 655, 656, 751, 752, 799};

  initial begin
    logic [31:0] mask;
    int ft_cnt;
    rst_n = 1'b0;
    vid.h_count = '0;
    vid.v_count = '0;
    vid.speed_sel = 2'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Boundary lines in full, then every line at the boundary columns.
    cnt_on = 1;
    foreach (lines[i]) for (int hh = 0; hh < 800; hh++) step(hh, lines[i]);
    for (int vv = 0; vv < 525; vv++) foreach (cols[j]) step(cols[j], vv);
    cnt_on = 0;
    chk("sweep_display_cnt", 32'(de_cnt), 32'd2880);
    chk("sweep_hsync_low",   32'(hs_cnt), 32'd1914);
    chk("sweep_vsync_low",   32'(vs_cnt), 32'd1616);

    // Held end-of-frame and held origin.
    step(798, 524);
    step(799, 524);
    step(799, 524);
    chk("hold_no_tick_at_799", 32'(vid.frame_tick), 32'd0);
    step(0, 0);
    chk("hold_first_origin_tick", 32'(vid.frame_tick), 32'd1);
    step(0, 0);
    chk("hold_second_origin_no_tick", 32'(vid.frame_tick), 32'd0);
    step(1, 0);
    chk("hold_after_origin_no_tick", 32'(vid.frame_tick), 32'd0);

    // speed_sel=0 across 16 frames.
    do_reset();
    vid.speed_sel = 2'd0;
    mask = 0; ft_cnt = 0;
    for (int f = 1; f <= 16; f++) begin
      frame();
      ft_cnt += int'(fr_ft);
      if (fr_mt) mask[f] = 1'b1;
    end
    chk("speed8_frame_ticks", 32'(ft_cnt), 32'd16);
    chk("speed8_move_frames", mask, 32'h0001_0100);

    // Speed-up from 8 to 1 frames with the counter at 5.
    do_reset();
    vid.speed_sel = 2'd0;
    mask = 0;
    for (int f = 0; f < 5; f++) begin
      frame();
      mask[f] = fr_mt;
    end
    chk("switch_no_early_move", mask, 32'd0);
    vid.speed_sel = 2'd3;
    mask = 0;
    for (int f = 0; f < 4; f++) begin
      frame();
      mask[f] = fr_mt & fr_ft;
    end
    chk("switch_move_every_frame", mask, 32'hF);

    // Out-of-range counts.
    do_reset();
    step(900, 491);
    chk("range_err_set",    32'(vid.range_err),  32'd1);
    chk("range_hsync_idle", 32'(vid.hsync),      32'd1);
    chk("range_vsync_idle", 32'(vid.vsync),      32'd1);
    chk("range_de_off",     32'(vid.display_en), 32'd0);
    step(5, 600);
    chk("range_v_de_off", 32'(vid.display_en), 32'd0);
    step(10, 10);
    chk("range_err_sticky",  32'(vid.range_err),  32'd1);
    chk("range_legal_de_on", 32'(vid.display_en), 32'd1);
    chk("range_legal_px",    32'(vid.pixel_x),    32'd10);
    do_reset();
    step(11, 10);
    chk("range_err_cleared", 32'(vid.range_err), 32'd0);

    // Reset asserted mid-line.
    step(299, 200);
    step(300, 200);
    chk("midline_de_before", 32'(vid.display_en), 32'd1);
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midline_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(301, 200);
    chk("midline_no_tick_on_release", 32'(vid.frame_tick), 32'd0);
    chk("midline_px_resumes",         32'(vid.pixel_x),    32'd301);
    step(799, 524);
    chk("midline_no_tick_before_wrap", 32'(vid.frame_tick), 32'd0);
    step(0, 0);
    chk("midline_tick_at_wrap", 32'(vid.frame_tick), 32'd1);
    step(1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
